// File: rtl/execute_stage.sv
// execute_stage
//   ALU, branch/jump resolution and the EX/MEM pipeline register.
//   Sits downstream of decoder_stage and feeds the memory stage.
//   A taken branch or jump issues a one-cycle redirect (ex_o_change_pc,
//   ex_o_alu_pc_value) to instruction_fetch, and flushes fetch/decode.
//
// Ports
//   ex_clk, ex_rst           clock, synchronous active-high reset
//   ex_i_ce                  decoded instruction valid
//   ex_i_pc, ex_i_imm        PC and sign-extended immediate
//   ex_i_addr_rs1/rs2/rd     register addresses
//   ex_i_rs1, ex_i_rs2       register operand values
//   ex_i_funct3, ex_i_alu, ex_i_opcode, ex_i_exception   decoded fields (one-hot alu/opcode)
//   ex_i_stall, ex_i_flush   downstream stall / flush
//   ex_o_*                   registered results for the memory stage, redirect,
//                            flush and stall requests to upstream stages
module execute_stage #(
    parameter int DWIDTH          = 32,
    parameter int AWIDTH          = 5,
    parameter int PC_WIDTH        = 32,
    parameter int ALU_WIDTH       = 14,
    parameter int OPCODE_WIDTH    = 11,
    parameter int EXCEPTION_WIDTH = 4
) (
    input  logic                       ex_clk,
    input  logic                       ex_rst,
    input  logic                       ex_i_ce,
    input  logic [PC_WIDTH-1:0]        ex_i_pc,
    input  logic [AWIDTH-1:0]          ex_i_addr_rs1,
    input  logic [AWIDTH-1:0]          ex_i_addr_rs2,
    input  logic [AWIDTH-1:0]          ex_i_addr_rd,
    input  logic [DWIDTH-1:0]          ex_i_rs1,
    input  logic [DWIDTH-1:0]          ex_i_rs2,
    input  logic [DWIDTH-1:0]          ex_i_imm,
    input  logic [2:0]                 ex_i_funct3,
    input  logic [ALU_WIDTH-1:0]       ex_i_alu,
    input  logic [OPCODE_WIDTH-1:0]    ex_i_opcode,
    input  logic [EXCEPTION_WIDTH-1:0] ex_i_exception,
    input  logic                       ex_i_stall,
    input  logic                       ex_i_flush,
    output logic                       ex_o_ce,
    output logic [DWIDTH-1:0]          ex_o_result,
    output logic [DWIDTH-1:0]          ex_o_rs2,
    output logic [AWIDTH-1:0]          ex_o_addr_rd,
    output logic                       ex_o_wr_rd,
    output logic [2:0]                 ex_o_funct3,
    output logic [OPCODE_WIDTH-1:0]    ex_o_opcode,
    output logic [EXCEPTION_WIDTH-1:0] ex_o_exception,
    output logic                       ex_o_misaligned,
    output logic                       ex_o_change_pc,
    output logic [PC_WIDTH-1:0]        ex_o_alu_pc_value,
    output logic                       ex_o_flush,
    output logic                       ex_o_stall
);
    localparam int OP_RTYPE = 0, OP_ITYPE = 1, OP_LOAD = 2, OP_STORE = 3, OP_BRANCH = 4;
    localparam int OP_JAL = 5, OP_JALR = 6, OP_LUI = 7, OP_AUIPC = 8;

    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b;
    logic [4:0]        shamt;
    logic [DWIDTH-1:0] op_val    [ALU_WIDTH];
    logic [DWIDTH-1:0] op_masked [ALU_WIDTH];
    logic [DWIDTH-1:0] alu_out;

    // Operand selection
    always_comb begin
        op_a = ex_i_rs1;
        if (ex_i_opcode[OP_AUIPC] || ex_i_opcode[OP_JAL]) begin
            op_a = DWIDTH'(ex_i_pc);
        end else if (ex_i_opcode[OP_LUI]) begin
            op_a = '0;
        end
        op_b = ex_i_rs2;
        if (ex_i_opcode[OP_ITYPE] || ex_i_opcode[OP_LOAD] || ex_i_opcode[OP_STORE] ||
            ex_i_opcode[OP_JALR]  || ex_i_opcode[OP_LUI]  || ex_i_opcode[OP_AUIPC] ||
            ex_i_opcode[OP_JAL]) begin
            op_b = ex_i_imm;
        end
    end

    assign shamt = op_b[4:0];

    // Every candidate result, indexed by its one-hot ALU bit
    always_comb begin
        for (int i = 0; i < ALU_WIDTH; i++) op_val[i] = '0;
        op_val[0]  = op_a + op_b;
        op_val[1]  = op_a - op_b;
        op_val[2]  = {{(DWIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        op_val[3]  = {{(DWIDTH-1){1'b0}}, (op_a < op_b)};
        op_val[4]  = op_a ^ op_b;
        op_val[5]  = op_a | op_b;
        op_val[6]  = op_a & op_b;
        op_val[7]  = op_a << shamt;
        op_val[8]  = op_a >> shamt;
        op_val[9]  = $unsigned($signed(op_a) >>> shamt);
        op_val[10] = {{(DWIDTH-1){1'b0}}, (op_a == op_b)};
        op_val[11] = {{(DWIDTH-1){1'b0}}, (op_a != op_b)};
        op_val[12] = {{(DWIDTH-1){1'b0}}, ($signed(op_a) >= $signed(op_b))};
        op_val[13] = {{(DWIDTH-1){1'b0}}, (op_a >= op_b)};
    end

    // One-hot select: mask each candidate by its op bit, then OR them together
    generate
        for (genvar gi = 0; gi < ALU_WIDTH; gi++) begin : g_alu_mask
            assign op_masked[gi] = {DWIDTH{ex_i_alu[gi]}} & op_val[gi];
        end
    endgenerate

    always_comb begin
        alu_out = '0;
        for (int i = 0; i < ALU_WIDTH; i++) alu_out = alu_out | op_masked[i];
    end

    // Branch / jump resolution
    logic [PC_WIDTH-1:0] link_addr;
    logic [PC_WIDTH-1:0] pc_rel_target;
    logic [PC_WIDTH-1:0] jalr_sum;
    logic [PC_WIDTH-1:0] target;
    logic                is_jump;
    logic                taken;
    logic                misaligned;
    logic                has_exception;
    logic                redirect;
    logic                writes_rd;
    logic                wr_rd;
    logic [DWIDTH-1:0]   result;

    assign link_addr     = ex_i_pc + PC_WIDTH'(4);
    assign pc_rel_target = ex_i_pc + PC_WIDTH'(ex_i_imm);
    assign jalr_sum      = PC_WIDTH'(ex_i_rs1 + ex_i_imm);
    assign target        = ex_i_opcode[OP_JALR] ? {jalr_sum[PC_WIDTH-1:1], 1'b0} : pc_rel_target;
    assign is_jump       = ex_i_opcode[OP_JAL] || ex_i_opcode[OP_JALR];
    assign taken         = is_jump || (ex_i_opcode[OP_BRANCH] && (alu_out == DWIDTH'(1)));
    assign misaligned    = taken && (target[1:0] != 2'b00);
    assign has_exception = |ex_i_exception;
    assign redirect      = taken && !misaligned && !has_exception;
    assign writes_rd     = ex_i_opcode[OP_RTYPE] || ex_i_opcode[OP_ITYPE] || ex_i_opcode[OP_LOAD] ||
                           is_jump || ex_i_opcode[OP_LUI] || ex_i_opcode[OP_AUIPC];
    assign wr_rd         = writes_rd && (|ex_i_addr_rd) && !has_exception && !misaligned;
    assign result        = is_jump ? DWIDTH'(link_addr) : alu_out;

    // Pipeline register
    logic                       ce_reg;
    logic [DWIDTH-1:0]          result_reg;
    logic [DWIDTH-1:0]          rs2_reg;
    logic [AWIDTH-1:0]          addr_rd_reg;
    logic                       wr_rd_reg;
    logic [2:0]                 funct3_reg;
    logic [OPCODE_WIDTH-1:0]    opcode_reg;
    logic [EXCEPTION_WIDTH-1:0] exception_reg;
    logic                       misaligned_reg;
    logic                       change_pc_reg;
    logic [PC_WIDTH-1:0]        pc_value_reg;
    // Set by a redirect; the next unstalled edge discards the wrong-path instruction.
    // Kept separate from change_pc_reg so the squash survives a stall that cut the pulse short.
    logic                       squash_reg;
    logic                       capture;

    assign capture = ex_i_ce && !ex_i_flush && !squash_reg;

    always_ff @(posedge ex_clk) begin
        if (ex_rst) begin
            ce_reg         <= 1'b0;
            result_reg     <= '0;
            rs2_reg        <= '0;
            addr_rd_reg    <= '0;
            wr_rd_reg      <= 1'b0;
            funct3_reg     <= '0;
            opcode_reg     <= '0;
            exception_reg  <= '0;
            misaligned_reg <= 1'b0;
            change_pc_reg  <= 1'b0;
            pc_value_reg   <= '0;
            squash_reg     <= 1'b0;
        end else if (ex_i_stall) begin
            change_pc_reg <= 1'b0;
        end else if (capture) begin
            ce_reg         <= 1'b1;
            result_reg     <= result;
            rs2_reg        <= ex_i_rs2;
            addr_rd_reg    <= ex_i_addr_rd;
            wr_rd_reg      <= wr_rd;
            funct3_reg     <= ex_i_funct3;
            opcode_reg     <= ex_i_opcode;
            exception_reg  <= ex_i_exception;
            misaligned_reg <= misaligned;
            change_pc_reg  <= redirect;
            pc_value_reg   <= target;
            squash_reg     <= redirect;
        end else begin
            ce_reg        <= 1'b0;
            wr_rd_reg     <= 1'b0;
            change_pc_reg <= 1'b0;
            squash_reg    <= 1'b0;
        end
    end

    assign ex_o_ce           = ce_reg;
    assign ex_o_result       = result_reg;
    assign ex_o_rs2          = rs2_reg;
    assign ex_o_addr_rd      = addr_rd_reg;
    assign ex_o_wr_rd        = wr_rd_reg;
    assign ex_o_funct3       = funct3_reg;
    assign ex_o_opcode       = opcode_reg;
    assign ex_o_exception    = exception_reg;
    assign ex_o_misaligned   = misaligned_reg;
    assign ex_o_change_pc    = change_pc_reg;
    assign ex_o_alu_pc_value = pc_value_reg;
    assign ex_o_flush        = ex_i_flush || change_pc_reg;
    assign ex_o_stall        = ex_i_stall;

    // Source register addresses are consumed by forwarding logic elsewhere
    logic unused_ok;
    assign unused_ok = ^{ex_i_addr_rs1, ex_i_addr_rs2};
endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    localparam int O_RTYPE = 0, O_ITYPE = 1, O_LOAD = 2, O_STORE = 3, O_BRANCH = 4;
    localparam int O_JAL = 5, O_JALR = 6, O_LUI = 7, O_AUIPC = 8;
    localparam int A_ADD = 0, A_SLT = 2, A_SLTU = 3, A_SRA = 9, A_EQ = 10, A_NEQ = 11;

    logic        ex_clk = 1'b0;
    logic        ex_rst, ex_i_ce, ex_i_stall, ex_i_flush;
    logic [31:0] ex_i_pc, ex_i_rs1, ex_i_rs2, ex_i_imm;
    logic [4:0]  ex_i_addr_rs1, ex_i_addr_rs2, ex_i_addr_rd;
    logic [2:0]  ex_i_funct3;
    logic [13:0] ex_i_alu;
    logic [10:0] ex_i_opcode;
    logic [3:0]  ex_i_exception;
    logic        ex_o_ce, ex_o_wr_rd, ex_o_misaligned, ex_o_change_pc, ex_o_flush, ex_o_stall;
    logic [31:0] ex_o_result, ex_o_rs2, ex_o_alu_pc_value;
    logic [4:0]  ex_o_addr_rd;
    logic [2:0]  ex_o_funct3;
    logic [10:0] ex_o_opcode;
    logic [3:0]  ex_o_exception;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage dut (
        .ex_clk(ex_clk), .ex_rst(ex_rst), .ex_i_ce(ex_i_ce), .ex_i_pc(ex_i_pc),
        .ex_i_addr_rs1(ex_i_addr_rs1), .ex_i_addr_rs2(ex_i_addr_rs2), .ex_i_addr_rd(ex_i_addr_rd),
        .ex_i_rs1(ex_i_rs1), .ex_i_rs2(ex_i_rs2), .ex_i_imm(ex_i_imm), .ex_i_funct3(ex_i_funct3),
        .ex_i_alu(ex_i_alu), .ex_i_opcode(ex_i_opcode), .ex_i_exception(ex_i_exception),
        .ex_i_stall(ex_i_stall), .ex_i_flush(ex_i_flush), .ex_o_ce(ex_o_ce),
        .ex_o_result(ex_o_result), .ex_o_rs2(ex_o_rs2), .ex_o_addr_rd(ex_o_addr_rd),
        .ex_o_wr_rd(ex_o_wr_rd), .ex_o_funct3(ex_o_funct3), .ex_o_opcode(ex_o_opcode),
        .ex_o_exception(ex_o_exception), .ex_o_misaligned(ex_o_misaligned),
        .ex_o_change_pc(ex_o_change_pc), .ex_o_alu_pc_value(ex_o_alu_pc_value),
        .ex_o_flush(ex_o_flush), .ex_o_stall(ex_o_stall)
    );

    always #5 ex_clk = ~ex_clk;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          alu;
        int          opc;
        logic [3:0]  exc;
        logic        ce;
    } instr_t;

    typedef struct {
        logic [31:0] result, target;
        logic        wr, redirect, mis;
    } exp_t;

    // Reference model: architectural meaning of one instruction
    function automatic exp_t model(instr_t t);
        exp_t r;
        logic [31:0] a, b, alu;
        int sh;
        logic taken;
        a = (t.opc == O_AUIPC || t.opc == O_JAL) ? t.pc : (t.opc == O_LUI) ? 32'd0 : t.rs1;
        b = (t.opc inside {O_ITYPE, O_LOAD, O_STORE, O_JALR, O_LUI, O_AUIPC, O_JAL}) ? t.imm : t.rs2;
        sh = int'(b % 32);
        case (t.alu)
            0:  alu = a + b;
            1:  alu = a - b;
            2:  alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3:  alu = (a < b) ? 32'd1 : 32'd0;
            4:  alu = a ^ b;
            5:  alu = a | b;
            6:  alu = a & b;
            7:  alu = a << sh;
            8:  alu = a >> sh;
            9:  alu = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            10: alu = (a == b) ? 32'd1 : 32'd0;
            11: alu = (a != b) ? 32'd1 : 32'd0;
            12: alu = (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
            default: alu = (a >= b) ? 32'd1 : 32'd0;
        endcase
        taken = (t.opc == O_JAL) || (t.opc == O_JALR) || (t.opc == O_BRANCH && alu == 32'd1);
        r.target = (t.opc == O_JALR) ? ((t.rs1 + t.imm) & 32'hFFFF_FFFE) : (t.pc + t.imm);
        r.mis = taken && (r.target % 4 != 0);
        r.redirect = taken && !r.mis && (t.exc == 0);
        r.wr = (t.opc inside {O_RTYPE, O_ITYPE, O_LOAD, O_JAL, O_JALR, O_LUI, O_AUIPC}) &&
               (t.rd != 0) && (t.exc == 0) && !r.mis;
        r.result = (t.opc == O_JAL || t.opc == O_JALR) ? t.pc + 32'd4 : alu;
        return r;
    endfunction

    function automatic instr_t mk(int opc, int alu, logic [31:0] pc, logic [31:0] rs1,
                                  logic [31:0] rs2, logic [31:0] imm, logic [4:0] rd);
        instr_t t;
        t.opc = opc; t.alu = alu; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        t.rd = rd; t.f3 = 3'd0; t.exc = 4'd0; t.ce = 1'b1;
        return t;
    endfunction

    task automatic set_in(instr_t t);
        ex_i_ce = t.ce; ex_i_pc = t.pc; ex_i_rs1 = t.rs1; ex_i_rs2 = t.rs2; ex_i_imm = t.imm;
        ex_i_addr_rd = t.rd; ex_i_addr_rs1 = 5'd1; ex_i_addr_rs2 = 5'd2; ex_i_funct3 = t.f3;
        ex_i_alu = '0; ex_i_alu[t.alu] = 1'b1;
        ex_i_opcode = '0; ex_i_opcode[t.opc] = 1'b1;
        ex_i_exception = t.exc;
    endtask

    task automatic idle();
        ex_i_ce = 1'b0;
    endtask

    task automatic step();
        @(posedge ex_clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(mk(O_RTYPE, A_ADD, 32'h10, 32'd3, 32'd4, 32'd0, 5'd7));
        ex_rst = 1'b1; ex_i_stall = 1'b0; ex_i_flush = 1'b0;
        step(); step();
        $display("reset: ce=%0b result=%h change_pc=%0b", ex_o_ce, ex_o_result, ex_o_change_pc);
        if (ex_o_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %0b want 0", ex_o_ce); end n_checks++;
        if (ex_o_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", ex_o_result); end n_checks++;
        if (ex_o_wr_rd !== 1'b0) begin n_fail++; $display("FAIL reset_wr_rd got %0b want 0", ex_o_wr_rd); end n_checks++;
        if (ex_o_change_pc !== 1'b0) begin n_fail++; $display("FAIL reset_change_pc got %0b want 0", ex_o_change_pc); end n_checks++;
        if (ex_o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %0b want 0", ex_o_flush); end n_checks++;
        if (ex_o_alu_pc_value !== 32'd0) begin n_fail++; $display("FAIL reset_pc_value got %h want 0", ex_o_alu_pc_value); end n_checks++;
        if (ex_o_addr_rd !== 5'd0) begin n_fail++; $display("FAIL reset_addr_rd got %0d want 0", ex_o_addr_rd); end n_checks++;
        ex_rst = 1'b0; idle();
        step();
    endtask

    task automatic test_add();
        set_in(mk(O_RTYPE, A_ADD, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3));
        step(); idle();
        $display("add 5+7 rd=3: ce=%0b result=%0d wr_rd=%0b", ex_o_ce, ex_o_result, ex_o_wr_rd);
        if (ex_o_ce !== 1'b1) begin n_fail++; $display("FAIL add_ce got %0b want 1", ex_o_ce); end n_checks++;
        if (ex_o_result !== 32'd12) begin n_fail++; $display("FAIL add_result got %0d want 12", ex_o_result); end n_checks++;
        if (ex_o_wr_rd !== 1'b1) begin n_fail++; $display("FAIL add_wr_rd got %0b want 1", ex_o_wr_rd); end n_checks++;
        if (ex_o_addr_rd !== 5'd3) begin n_fail++; $display("FAIL add_addr_rd got %0d want 3", ex_o_addr_rd); end n_checks++;
        step();
        if (ex_o_ce !== 1'b0) begin n_fail++; $display("FAIL add_bubble_ce got %0b want 0", ex_o_ce); end n_checks++;
    endtask

    task automatic test_shift_compare();
        set_in(mk(O_ITYPE, A_SRA, 32'h0, 32'h8000_0000, 32'd0, 32'd4, 5'd5));
        step();
        $display("sra 0x80000000>>>4: result=%h", ex_o_result);
        if (ex_o_result !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_result got %h want f8000000", ex_o_result); end n_checks++;
        set_in(mk(O_RTYPE, A_SLTU, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd5));
        step();
        $display("sltu 1 vs ffffffff: result=%h", ex_o_result);
        if (ex_o_result !== 32'd1) begin n_fail++; $display("FAIL sltu_result got %h want 1", ex_o_result); end n_checks++;
        set_in(mk(O_RTYPE, A_SLT, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd5));
        step(); idle();
        $display("slt 1 vs ffffffff: result=%h", ex_o_result);
        if (ex_o_result !== 32'd0) begin n_fail++; $display("FAIL slt_result got %h want 0", ex_o_result); end n_checks++;
        step();
    endtask

    task automatic test_branch();
        set_in(mk(O_BRANCH, A_EQ, 32'h100, 32'd9, 32'd9, 32'h20, 5'd0));
        step();
        $display("beq taken: change_pc=%0b flush=%0b target=%h", ex_o_change_pc, ex_o_flush, ex_o_alu_pc_value);
        if (ex_o_change_pc !== 1'b1) begin n_fail++; $display("FAIL beq_change_pc got %0b want 1", ex_o_change_pc); end n_checks++;
        if (ex_o_flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush got %0b want 1", ex_o_flush); end n_checks++;
        if (ex_o_alu_pc_value !== 32'h120) begin n_fail++; $display("FAIL beq_target got %h want 120", ex_o_alu_pc_value); end n_checks++;
        if (ex_o_wr_rd !== 1'b0) begin n_fail++; $display("FAIL beq_wr_rd got %0b want 0", ex_o_wr_rd); end n_checks++;
        // wrong-path instruction presented during the redirect cycle
        set_in(mk(O_RTYPE, A_ADD, 32'h104, 32'd1, 32'd1, 32'd0, 5'd4));
        step();
        $display("after beq: ce=%0b change_pc=%0b flush=%0b", ex_o_ce, ex_o_change_pc, ex_o_flush);
        if (ex_o_ce !== 1'b0) begin n_fail++; $display("FAIL squash_ce got %0b want 0", ex_o_ce); end n_checks++;
        if (ex_o_change_pc !== 1'b0) begin n_fail++; $display("FAIL pulse_change_pc got %0b want 0", ex_o_change_pc); end n_checks++;
        if (ex_o_flush !== 1'b0) begin n_fail++; $display("FAIL pulse_flush got %0b want 0", ex_o_flush); end n_checks++;
        set_in(mk(O_BRANCH, A_NEQ, 32'h100, 32'd9, 32'd9, 32'h20, 5'd0));
        step(); idle();
        $display("bne equal: ce=%0b change_pc=%0b", ex_o_ce, ex_o_change_pc);
        if (ex_o_ce !== 1'b1) begin n_fail++; $display("FAIL bne_ce got %0b want 1", ex_o_ce); end n_checks++;
        if (ex_o_change_pc !== 1'b0) begin n_fail++; $display("FAIL bne_change_pc got %0b want 0", ex_o_change_pc); end n_checks++;
        step();
    endtask

    task automatic test_jump();
        instr_t t;
        set_in(mk(O_JAL, A_ADD, 32'h40, 32'd0, 32'd0, 32'd8, 5'd1));
        step(); idle();
        $display("jal: result=%h target=%h change_pc=%0b wr=%0b", ex_o_result, ex_o_alu_pc_value, ex_o_change_pc, ex_o_wr_rd);
        if (ex_o_result !== 32'h44) begin n_fail++; $display("FAIL jal_result got %h want 44", ex_o_result); end n_checks++;
        if (ex_o_alu_pc_value !== 32'h48) begin n_fail++; $display("FAIL jal_target got %h want 48", ex_o_alu_pc_value); end n_checks++;
        if (ex_o_change_pc !== 1'b1) begin n_fail++; $display("FAIL jal_change_pc got %0b want 1", ex_o_change_pc); end n_checks++;
        if (ex_o_wr_rd !== 1'b1) begin n_fail++; $display("FAIL jal_wr_rd got %0b want 1", ex_o_wr_rd); end n_checks++;
        step();
        set_in(mk(O_JALR, A_ADD, 32'h80, 32'h203, 32'd0, 32'd0, 5'd1));
        step(); idle();
        $display("jalr misaligned: target=%h mis=%0b change_pc=%0b wr=%0b", ex_o_alu_pc_value, ex_o_misaligned, ex_o_change_pc, ex_o_wr_rd);
        if (ex_o_alu_pc_value !== 32'h202) begin n_fail++; $display("FAIL jalr_target got %h want 202", ex_o_alu_pc_value); end n_checks++;
        if (ex_o_misaligned !== 1'b1) begin n_fail++; $display("FAIL jalr_misaligned got %0b want 1", ex_o_misaligned); end n_checks++;
        if (ex_o_change_pc !== 1'b0) begin n_fail++; $display("FAIL jalr_change_pc got %0b want 0", ex_o_change_pc); end n_checks++;
        if (ex_o_wr_rd !== 1'b0) begin n_fail++; $display("FAIL jalr_wr_rd got %0b want 0", ex_o_wr_rd); end n_checks++;
        step();
        t = mk(O_JAL, A_ADD, 32'h40, 32'd0, 32'd0, 32'd8, 5'd1);
        t.exc = 4'b0010;
        set_in(t);
        step(); idle();
        $display("jal with exception: change_pc=%0b wr=%0b exc=%b", ex_o_change_pc, ex_o_wr_rd, ex_o_exception);
        if (ex_o_change_pc !== 1'b0) begin n_fail++; $display("FAIL exc_change_pc got %0b want 0", ex_o_change_pc); end n_checks++;
        if (ex_o_wr_rd !== 1'b0) begin n_fail++; $display("FAIL exc_wr_rd got %0b want 0", ex_o_wr_rd); end n_checks++;
        if (ex_o_exception !== 4'b0010) begin n_fail++; $display("FAIL exc_pass got %b want 0010", ex_o_exception); end n_checks++;
        step();
    endtask

    task automatic test_stall();
        int pulses;
        set_in(mk(O_BRANCH, A_EQ, 32'h100, 32'd3, 32'd3, 32'h20, 5'd0));
        step();
        pulses = (ex_o_change_pc === 1'b1) ? 1 : 0;
        ex_i_stall = 1'b1;
        set_in(mk(O_RTYPE, A_ADD, 32'h200, 32'd50, 32'd60, 32'd0, 5'd9));
        for (int i = 0; i < 3; i++) begin
            step();
            if (ex_o_change_pc === 1'b1) pulses++;
            $display("stall cycle %0d: ce=%0b result=%h target=%h stall=%0b", i, ex_o_ce, ex_o_result, ex_o_alu_pc_value, ex_o_stall);
            if (ex_o_ce !== 1'b1) begin n_fail++; $display("FAIL stall_ce got %0b want 1", ex_o_ce); end n_checks++;
            if (ex_o_result !== 32'd1) begin n_fail++; $display("FAIL stall_result got %h want 1", ex_o_result); end n_checks++;
            if (ex_o_alu_pc_value !== 32'h120) begin n_fail++; $display("FAIL stall_target got %h want 120", ex_o_alu_pc_value); end n_checks++;
            if (ex_o_stall !== 1'b1) begin n_fail++; $display("FAIL stall_out got %0b want 1", ex_o_stall); end n_checks++;
        end
        if (pulses != 1) begin n_fail++; $display("FAIL stall_pulses got %0d want 1", pulses); end n_checks++;
        ex_i_stall = 1'b0; idle();
        step(); step();
        if (ex_o_stall !== 1'b0) begin n_fail++; $display("FAIL unstall_out got %0b want 0", ex_o_stall); end n_checks++;
    endtask

    task automatic test_flush();
        set_in(mk(O_BRANCH, A_EQ, 32'h100, 32'd3, 32'd3, 32'h20, 5'd0));
        ex_i_flush = 1'b1;
        #1;
        if (ex_o_flush !== 1'b1) begin n_fail++; $display("FAIL flush_passthru got %0b want 1", ex_o_flush); end n_checks++;
        step();
        ex_i_flush = 1'b0;
        #1;
        $display("beq with flush: ce=%0b change_pc=%0b flush=%0b", ex_o_ce, ex_o_change_pc, ex_o_flush);
        if (ex_o_ce !== 1'b0) begin n_fail++; $display("FAIL flush_ce got %0b want 0", ex_o_ce); end n_checks++;
        if (ex_o_change_pc !== 1'b0) begin n_fail++; $display("FAIL flush_change_pc got %0b want 0", ex_o_change_pc); end n_checks++;
        if (ex_o_flush !== 1'b0) begin n_fail++; $display("FAIL flush_out got %0b want 0", ex_o_flush); end n_checks++;
        set_in(mk(O_RTYPE, A_ADD, 32'h0, 32'd2, 32'd3, 32'd0, 5'd0));
        step(); idle();
        $display("add rd=0: ce=%0b result=%0d wr=%0b", ex_o_ce, ex_o_result, ex_o_wr_rd);
        if (ex_o_ce !== 1'b1) begin n_fail++; $display("FAIL rd0_ce got %0b want 1", ex_o_ce); end n_checks++;
        if (ex_o_result !== 32'd5) begin n_fail++; $display("FAIL rd0_result got %0d want 5", ex_o_result); end n_checks++;
        if (ex_o_wr_rd !== 1'b0) begin n_fail++; $display("FAIL rd0_wr_rd got %0b want 0", ex_o_wr_rd); end n_checks++;
        step();
    endtask

    function automatic instr_t rand_instr();
        instr_t t;
        int kinds[9] = '{O_RTYPE, O_ITYPE, O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_LUI, O_AUIPC};
        int br_ops[6] = '{2, 3, 10, 11, 12, 13};
        t.opc = kinds[$urandom_range(0, 8)];
        if (t.opc == O_RTYPE || t.opc == O_ITYPE) t.alu = $urandom_range(0, 9);
        else if (t.opc == O_BRANCH) t.alu = br_ops[$urandom_range(0, 5)];
        else t.alu = A_ADD;
        t.pc  = $urandom() & 32'hFFFF_FFFC;
        t.rs1 = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 8)) - 4) : $urandom();
        t.rs2 = ($urandom_range(0, 2) == 0) ? t.rs1 : $urandom();
        t.imm = 32'(int'($urandom_range(0, 255)) - 128);
        t.rd  = 5'($urandom_range(0, 31));
        t.f3  = 3'($urandom_range(0, 7));
        t.exc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        t.ce  = ($urandom_range(0, 4) != 0);
        return t;
    endfunction

    task automatic test_random();
        instr_t t;
        exp_t m;
        logic e_ce = 0, e_wr = 0, e_chg = 0, e_mis = 0, squash = 0;
        logic [31:0] e_res = 0, e_tgt = 0, e_rs2 = 0;
        logic [4:0] e_rd = 0;
        logic [10:0] e_opc = 0;
        logic st, fl;
        // reset mid-operation clears everything, including any pending squash
        ex_rst = 1'b1; step(); ex_rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            t = rand_instr();
            st = ($urandom_range(0, 9) == 0);
            fl = !st && ($urandom_range(0, 9) == 0);
            set_in(t); ex_i_stall = st; ex_i_flush = fl;
            #1;
            if (ex_o_flush !== (fl | e_chg)) begin n_fail++; $display("FAIL rnd_flush_out txn %0d got %0b want %0b", n, ex_o_flush, fl | e_chg); end n_checks++;
            if (ex_o_stall !== st) begin n_fail++; $display("FAIL rnd_stall_out txn %0d got %0b want %0b", n, ex_o_stall, st); end n_checks++;
            if (st) begin
                e_chg = 0;
            end else if (t.ce && !fl && !squash) begin
                m = model(t);
                e_ce = 1; e_res = m.result; e_wr = m.wr; e_chg = m.redirect; e_mis = m.mis;
                e_tgt = m.target; e_rd = t.rd; e_rs2 = t.rs2; e_opc = 11'(1) << t.opc; squash = m.redirect;
            end else begin
                e_ce = 0; e_wr = 0; e_chg = 0; squash = 0;
            end
            step();
            $display("txn %0d opc=%0d alu=%0d ce=%0b stall=%0b flush=%0b -> ce=%0b res=%h wr=%0b chg=%0b mis=%0b",
                     n, t.opc, t.alu, t.ce, st, fl, ex_o_ce, ex_o_result, ex_o_wr_rd, ex_o_change_pc, ex_o_misaligned);
            if (ex_o_ce !== e_ce) begin n_fail++; $display("FAIL rnd_ce txn %0d got %0b want %0b", n, ex_o_ce, e_ce); end n_checks++;
            if (ex_o_result !== e_res) begin n_fail++; $display("FAIL rnd_result txn %0d got %h want %h", n, ex_o_result, e_res); end n_checks++;
            if (ex_o_wr_rd !== e_wr) begin n_fail++; $display("FAIL rnd_wr_rd txn %0d got %0b want %0b", n, ex_o_wr_rd, e_wr); end n_checks++;
            if (ex_o_change_pc !== e_chg) begin n_fail++; $display("FAIL rnd_change_pc txn %0d got %0b want %0b", n, ex_o_change_pc, e_chg); end n_checks++;
            if (ex_o_misaligned !== e_mis) begin n_fail++; $display("FAIL rnd_misaligned txn %0d got %0b want %0b", n, ex_o_misaligned, e_mis); end n_checks++;
            if (ex_o_alu_pc_value !== e_tgt) begin n_fail++; $display("FAIL rnd_target txn %0d got %h want %h", n, ex_o_alu_pc_value, e_tgt); end n_checks++;
            if (ex_o_addr_rd !== e_rd) begin n_fail++; $display("FAIL rnd_addr_rd txn %0d got %0d want %0d", n, ex_o_addr_rd, e_rd); end n_checks++;
            if (ex_o_rs2 !== e_rs2) begin n_fail++; $display("FAIL rnd_rs2 txn %0d got %h want %h", n, ex_o_rs2, e_rs2); end n_checks++;
            if (ex_o_opcode !== e_opc) begin n_fail++; $display("FAIL rnd_opcode txn %0d got %h want %h", n, ex_o_opcode, e_opc); end n_checks++;
        end
        ex_i_stall = 1'b0; ex_i_flush = 1'b0; idle();
    endtask

    initial begin
        ex_rst = 1'b1; ex_i_stall = 1'b0; ex_i_flush = 1'b0;
        set_in(mk(O_RTYPE, A_ADD, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0));
        idle();
        test_reset();
        test_add();
        test_shift_compare();
        test_branch();
        test_jump();
        test_stall();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline stage directly downstream of `decoder_stage`; consumes its decoded fields and register operands. Performs the ALU operation, resolves branches and jumps, and registers the results for the memory stage. On a taken branch or jump it drives `ex_o_change_pc` / `ex_o_alu_pc_value` back to `instruction_fetch` and flushes the younger in-flight instructions. Participates in the `ce` / stall / flush pipeline protocol like the other stages.

## Interface
- DWIDTH, 32, data / operand width
- AWIDTH, 5, register address width
- PC_WIDTH, 32, program counter width
- ex_clk  in  1  clock
- ex_rst  in  1  reset; synchronous, active-high
- ex_i_ce  in  1  decoder output valid (`ds_o_ce`)
- ex_i_pc  in  PC_WIDTH  PC of the decoded instruction
- ex_i_addr_rs1, ex_i_addr_rs2, ex_i_addr_rd  in  AWIDTH  register addresses
- ex_i_rs1, ex_i_rs2  in  DWIDTH  register operand values
- ex_i_imm  in  DWIDTH  sign-extended immediate
- ex_i_funct3  in  3  funct3 field, passed through to memory stage
- ex_i_alu  in  `ALU_WIDTH`  one-hot op: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 EQ, 11 NEQ, 12 GE, 13 GEU
- ex_i_opcode  in  `OPCODE_WIDTH`  one-hot: 0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE
- ex_i_exception  in  `EXCEPTION_WIDTH`  decoder exception flags, passed through
- ex_i_stall  in  1  downstream stall
- ex_i_flush  in  1  downstream flush
- ex_o_ce  out  1  outputs valid for memory stage
- ex_o_result  out  DWIDTH  ALU result, or link address for JAL/JALR
- ex_o_rs2  out  DWIDTH  store data
- ex_o_addr_rd  out  AWIDTH  destination register
- ex_o_wr_rd  out  1  register write-back enable
- ex_o_funct3  out  3  registered funct3
- ex_o_opcode  out  `OPCODE_WIDTH`  registered opcode
- ex_o_exception  out  `EXCEPTION_WIDTH`  registered exception flags
- ex_o_misaligned  out  1  taken target not 4-byte aligned
- ex_o_change_pc  out  1  redirect fetch (one-cycle pulse)
- ex_o_alu_pc_value  out  PC_WIDTH  redirect target
- ex_o_flush  out  1  flush fetch and decode
- ex_o_stall  out  1  stall request to upstream stages

## Operation
- Operand A: `ex_i_pc` for AUIPC and JAL, 0 for LUI, otherwise `ex_i_rs1`.
- Operand B: `ex_i_imm` for ITYPE, LOAD, STORE, JALR, LUI, AUIPC, JAL; otherwise `ex_i_rs2`.
- Shifts use B[4:0]. SRA is arithmetic. Compare ops (SLT/SLTU/EQ/NEQ/GE/GEU) yield 1 or 0 zero-extended. Add/sub wrap modulo 2^DWIDTH.
- Branch taken when BRANCH and compare result = 1. Branch target is `pc + imm`. JAL target is `pc + imm`. JALR target is `(rs1 + imm) & ~1`.
- For JAL and JALR, `ex_o_result` = `pc + 4`. Otherwise it is the ALU output.
- `ex_o_wr_rd` = 1 for RTYPE, ITYPE, LOAD, JAL, JALR, LUI, AUIPC, and only when rd ≠ 0.
- Taken target with [1:0] ≠ 0:
  - `ex_o_misaligned` = 1, `ex_o_change_pc` = 0.
  - `ex_o_wr_rd` = 0.
- Any bit of `ex_i_exception` set forces `ex_o_wr_rd` = 0 and suppresses redirect.
- `ex_o_stall` = `ex_i_stall`.
- `ex_o_flush` = `ex_i_flush` OR a registered redirect.

## Timing
- Reset: every output register is 0, including `ex_o_ce`, `ex_o_change_pc`, `ex_o_flush`, `ex_o_result`, and `ex_o_alu_pc_value`.
- Latency is 1 cycle: an instruction accepted at edge N has its outputs visible after edge N.
- Capture condition: `ex_i_ce` = 1 and `ex_i_stall` = 0 and no flush.
  - Otherwise, if not stalled, `ex_o_ce` ← 0 and side-effect outputs (`ex_o_wr_rd`, `ex_o_change_pc`) ← 0.
- Stall (`ex_i_stall` = 1): all output registers hold. `ex_o_change_pc` is forced low so a redirect is never repeated.
- Redirect pulse: `ex_o_change_pc` and `ex_o_flush` are high for exactly the one cycle after capture.
  - The following cycle, the stage ignores `ex_i_ce` (wrong-path squash) and outputs `ex_o_ce` = 0.
- `ex_i_flush` has priority over capture. The next edge gives `ex_o_ce` = 0 and `ex_o_wr_rd` = 0.
- A redirect and `ex_i_flush` in the same cycle: the flush wins and no redirect is issued.
- Reset mid-operation clears any pending redirect and squash.

## Test plan
- Reset → all outputs 0. Then ADD with rs1 = 5, rs2 = 7, rd = 3, ce = 1 → next cycle `ex_o_ce` = 1, `ex_o_result` = 12, `ex_o_wr_rd` = 1.
- Shifts and compares:
  - SRA with rs1 = 0x80000000, imm = 4 → 0xF8000000.
  - SLTU with 1 vs 0xFFFFFFFF → 1.
  - SLT with 1 vs 0xFFFFFFFF → 0.
- Branches at pc = 0x100, imm = 0x20:
  - BEQ with rs1 = rs2 → `ex_o_change_pc` = 1 and `ex_o_flush` = 1 for one cycle, `ex_o_alu_pc_value` = 0x120. The next `ex_i_ce` is squashed.
  - BNE with rs1 = rs2 → no redirect.
- Jumps:
  - JAL at pc = 0x40, imm = 8 → result 0x44, target 0x48.
  - JALR with rs1 = 0x203, imm = 0 → target 0x202, `ex_o_misaligned` = 1, no redirect, `ex_o_wr_rd` = 0.
- Stall: hold `ex_i_stall` = 1 for 3 cycles after a taken branch is accepted → outputs frozen, `ex_o_change_pc` high for only 1 cycle in total, `ex_o_stall` = 1.
- Flush: assert `ex_i_flush` in the same cycle as a taken BEQ → `ex_o_ce` = 0, no redirect. Also verify that rd = 0 ADD gives `ex_o_wr_rd` = 0.
